// File: rtl/mult_job_sequencer.sv
// Operand-pair job queue feeding an external multiplier through a start/ready handshake;
// results come back tagged with an 8-bit job sequence number behind a valid/ready output register.
module mult_job_sequencer #(
    parameter int dp_width   = 8,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [dp_width-1:0]   in_a,
    input  logic [dp_width-1:0]   in_b,
    output logic                  mul_start,
    output logic [dp_width-1:0]   mul_multiplicand,
    output logic [dp_width-1:0]   mul_multiplier,
    input  logic                  mul_rdy,
    input  logic [2*dp_width-1:0] mul_product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*dp_width-1:0] out_product,
    output logic [7:0]            out_tag,
    output logic                  busy,
    output logic                  proto_err
);

    // state     | meaning
    // S_idle    | waiting for a queued job and an idle multiplier; issues the start pulse
    // S_launch  | start just issued; the multiplier must drop mul_rdy now
    // S_wait    | multiplier working; wait for mul_rdy to return
    // S_capture | product ready; load the output register once it is free
    typedef enum logic [1:0] {S_idle, S_launch, S_wait, S_capture} state_t;

    localparam int ptr_w  = $clog2(fifo_depth);
    localparam int word_w = 8 + 2 * dp_width;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [word_w-1:0]     r_mem [fifo_depth];
    logic [ptr_w:0]        r_wr_ptr;
    logic [ptr_w:0]        r_rd_ptr;
    logic [7:0]            r_tag_cnt;
    logic [7:0]            r_job_tag;
    logic [dp_width-1:0]   r_last_a;
    logic [dp_width-1:0]   r_last_b;
    logic                  r_out_valid;
    logic [2*dp_width-1:0] r_out_product;
    logic [7:0]            r_out_tag;
    logic                  r_proto_err;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_capture;
    logic                  w_proto;
    logic [word_w-1:0]     w_head;
    logic [7:0]            w_head_tag;
    logic [dp_width-1:0]   w_head_a;
    logic [dp_width-1:0]   w_head_b;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[ptr_w] != r_rd_ptr[ptr_w]) &&
                        (r_wr_ptr[ptr_w-1:0] == r_rd_ptr[ptr_w-1:0]);
    assign w_push     = in_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr[ptr_w-1:0]];
    assign w_head_tag = w_head[word_w-1 -: 8];
    assign w_head_a   = w_head[2*dp_width-1 -: dp_width];
    assign w_head_b   = w_head[dp_width-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_proto     = 1'b0;
        case (r_state)
            S_idle: begin
                if (!w_empty && mul_rdy) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_launch;
                end
            end
            S_launch: begin
                if (mul_rdy) begin
                    w_proto     = 1'b1;
                    w_state_nxt = S_idle;
                end else begin
                    w_state_nxt = S_wait;
                end
            end
            S_wait: begin
                if (mul_rdy) w_state_nxt = S_capture;
            end
            S_capture: begin
                if (!r_out_valid || out_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_idle;
                end
            end
            default: w_state_nxt = S_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_idle;
        else        r_state <= w_state_nxt;
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[ptr_w-1:0]] <= {r_tag_cnt, in_a, in_b};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_tag_cnt <= r_tag_cnt + 8'd1;
            end
            if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_job_tag <= '0;
            r_last_a  <= '0;
            r_last_b  <= '0;
        end else if (w_issue) begin
            r_job_tag <= w_head_tag;
            r_last_a  <= w_head_a;
            r_last_b  <= w_head_b;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_tag     <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_out_valid   <= 1'b1;
                r_out_product <= mul_product;
                r_out_tag     <= r_job_tag;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_proto) r_proto_err <= 1'b1;
        end
    end

    // Head operands are shown during the start cycle, the last issued pair otherwise.
    assign mul_start        = w_issue;
    assign mul_multiplicand = w_issue ? w_head_a : r_last_a;
    assign mul_multiplier   = w_issue ? w_head_b : r_last_b;
    assign in_ready         = !w_full;
    assign out_valid        = r_out_valid;
    assign out_product      = r_out_product;
    assign out_tag          = r_out_tag;
    assign busy             = !w_empty || (r_state != S_idle);
    assign proto_err        = r_proto_err;

endmodule
